// File: rtl/bf16_to_bcd_disp_pkg.sv
// Shared constants, FSM encoding and the BCD digit-adjust helper for the
// BF16-to-decimal display converter.
package bf16_to_bcd_disp_pkg;

   localparam int BF16_SIGN_W   = 1;
   localparam int BF16_EXP_W    = 8;
   localparam int BF16_FRAC_W   = 7;
   localparam int BF16_EXP_BIAS = 127;
   localparam int DISP_DIGITS   = 4;
   localparam int NBITS         = 24;

   localparam logic [9:0]       DISP_SCALE = 10'd1000;
   localparam logic [7:0]       OVF_EXP    = 8'd141;
   // Exponent at which m*SCALE already carries the right weight (bias + fraction bits).
   localparam logic [7:0]       UNITY_EXP  = 8'(BF16_EXP_BIAS + BF16_FRAC_W);
   localparam logic [NBITS-1:0] N_OVF      = 24'd10_000_000;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DECODE = 3'd1,
      S_BCD    = 3'd2,
      S_SELECT = 3'd3,
      S_FINISH = 3'd4
   } state_t;

   function automatic logic [31:0] bcd_adjust(input logic [31:0] bcd);
      logic [31:0] res;
      res = bcd;
      for (int i = 0; i < 8; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) begin
            res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
         end else begin
            res[4*i +: 4] = bcd[4*i +: 4];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/bf16_to_bcd_disp_bin_to_bcd.sv
// Sequential 24-bit double-dabble: one shift-add-3 step per cycle, 24 cycles.
// o_done marks the cycle whose clock edge completes the last shift.
module bf16_to_bcd_disp_bin_to_bcd
   import bf16_to_bcd_disp_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_start,
   input  logic [NBITS-1:0] i_bin,
   output logic [31:0]      o_bcd,
   output logic             o_done
);

   localparam logic [4:0] LAST_CNT = 5'(NBITS - 1);

   logic [NBITS-1:0] r_bin;
   logic [31:0]      r_bcd;
   logic [4:0]       r_cnt;
   logic             r_busy;
   logic [31:0]      w_adj;

   assign w_adj  = bcd_adjust(r_bcd);
   assign o_bcd  = r_bcd;
   assign o_done = r_busy && (r_cnt == LAST_CNT);

   // Load on start, then shift one binary bit into the adjusted BCD word per cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bin  <= '0;
         r_bcd  <= '0;
         r_cnt  <= 5'd0;
         r_busy <= 1'b0;
      end else if (r_busy) begin
         {r_bcd, r_bin} <= {w_adj, r_bin} << 1;
         r_cnt          <= r_cnt + 5'd1;
         r_busy         <= (r_cnt != LAST_CNT);
      end else if (i_start) begin
         r_bin  <= i_bin;
         r_bcd  <= '0;
         r_cnt  <= 5'd0;
         r_busy <= 1'b1;
      end else begin
         r_busy <= 1'b0;
      end
   end

endmodule

// File: rtl/bf16_to_bcd_disp.sv
// BF16 result -> 4-digit BCD display word with decimal point, sign, NaN and
// overflow flags. Decode/scale, 24-cycle double-dabble, then digit-window select.
module bf16_to_bcd_disp
   import bf16_to_bcd_disp_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_start,
   input  logic [15:0]                i_bf16_in,
   input  logic                       i_err_in,
   output logic [4*DISP_DIGITS-1:0]   o_digits,
   output logic [1:0]                 o_frac_digits,
   output logic                       o_neg,
   output logic                       o_nan,
   output logic                       o_ovf,
   output logic                       o_busy,
   output logic                       o_done
);

   state_t r_state, w_state_nxt;

   logic [15:0]      r_bf16,       w_bf16_nxt;
   logic             r_err,        w_err_nxt;
   logic [NBITS-1:0] r_n,          w_n_nxt;
   logic [15:0]      r_res_digits, w_res_digits_nxt;
   logic [1:0]       r_res_frac,   w_res_frac_nxt;
   logic             r_res_neg,    w_res_neg_nxt;
   logic             r_res_nan,    w_res_nan_nxt;
   logic             r_res_ovf,    w_res_ovf_nxt;
   logic [15:0]      r_digits,     w_digits_nxt;
   logic [1:0]       r_frac,       w_frac_nxt;
   logic             r_neg,        w_neg_nxt;
   logic             r_nan,        w_nan_nxt;
   logic             r_ovf,        w_ovf_nxt;
   logic             r_busy,       w_busy_nxt;
   logic             r_done,       w_done_nxt;

   logic [BF16_EXP_W-1:0]  w_exp;
   logic [BF16_FRAC_W-1:0] w_frac;
   logic [7:0]             w_mant;
   logic                   w_sign;
   logic                   w_is_nan;
   logic                   w_is_ovf;
   logic [NBITS-1:0]       w_p;
   logic [7:0]             w_rsh;
   logic [NBITS-1:0]       w_round;
   logic [NBITS-1:0]       w_n_dec;
   logic                   w_bcd_start;
   logic                   w_bcd_done;
   logic [31:0]            w_bcd;

   assign w_sign   = r_bf16[15 -: BF16_SIGN_W];
   assign w_exp    = r_bf16[14:7];
   assign w_frac   = r_bf16[6:0];
   assign w_mant   = {1'b1, w_frac};
   assign w_is_nan = r_err || ((w_exp == 8'hFF) && (w_frac != 7'd0));
   assign w_is_ovf = (w_exp >= OVF_EXP);
   assign w_p      = 24'(w_mant) * 24'(DISP_SCALE);
   assign w_rsh    = UNITY_EXP - w_exp;

   // Scaled integer N = round(|x| * 1000), half rounded up on right shifts.
   always_comb begin
      w_n_dec = '0;
      w_round = '0;
      if (w_exp == 8'd0) begin
         w_n_dec = '0;
      end else if (w_exp >= UNITY_EXP) begin
         w_n_dec = w_p << (w_exp - UNITY_EXP);
      end else if (w_rsh <= 8'd18) begin
         w_round = 24'd1 << (w_rsh - 8'd1);
         w_n_dec = (w_p + w_round) >> w_rsh;
      end else begin
         w_n_dec = '0;
      end
   end

   bf16_to_bcd_disp_bin_to_bcd u_bin_to_bcd (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_start (w_bcd_start),
      .i_bin   (w_n_dec),
      .o_bcd   (w_bcd),
      .o_done  (w_bcd_done)
   );

   // Next-state, result staging and output-register logic.
   always_comb begin
      w_state_nxt      = r_state;
      w_bf16_nxt       = r_bf16;
      w_err_nxt        = r_err;
      w_n_nxt          = r_n;
      w_res_digits_nxt = r_res_digits;
      w_res_frac_nxt   = r_res_frac;
      w_res_neg_nxt    = r_res_neg;
      w_res_nan_nxt    = r_res_nan;
      w_res_ovf_nxt    = r_res_ovf;
      w_digits_nxt     = r_digits;
      w_frac_nxt       = r_frac;
      w_neg_nxt        = r_neg;
      w_nan_nxt        = r_nan;
      w_ovf_nxt        = r_ovf;
      w_busy_nxt       = r_busy;
      w_done_nxt       = 1'b0;
      w_bcd_start      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_bf16_nxt  = i_bf16_in;
               w_err_nxt   = i_err_in;
               w_busy_nxt  = 1'b1;
               w_state_nxt = S_DECODE;
            end else begin
               w_busy_nxt  = 1'b0;
            end
         end
         S_DECODE: begin
            w_res_digits_nxt = 16'd0;
            w_res_frac_nxt   = 2'd0;
            w_res_neg_nxt    = 1'b0;
            if (w_is_nan) begin
               w_res_nan_nxt = 1'b1;
               w_res_ovf_nxt = 1'b0;
               w_state_nxt   = S_FINISH;
            end else if (w_is_ovf) begin
               w_res_nan_nxt = 1'b0;
               w_res_ovf_nxt = 1'b1;
               w_state_nxt   = S_FINISH;
            end else begin
               w_n_nxt     = w_n_dec;
               w_bcd_start = 1'b1;
               w_state_nxt = S_BCD;
            end
         end
         S_BCD: begin
            if (w_bcd_done) begin
               if (r_n >= N_OVF) begin
                  w_res_digits_nxt = 16'd0;
                  w_res_frac_nxt   = 2'd0;
                  w_res_neg_nxt    = 1'b0;
                  w_res_nan_nxt    = 1'b0;
                  w_res_ovf_nxt    = 1'b1;
                  w_state_nxt      = S_FINISH;
               end else begin
                  w_state_nxt      = S_SELECT;
               end
            end else begin
               w_state_nxt = S_BCD;
            end
         end
         S_SELECT: begin
            // Window starts at the highest nonzero digit among D6..D4, else D3.
            if (w_bcd[27:24] != 4'd0) begin
               w_res_digits_nxt = w_bcd[27:12];
               w_res_frac_nxt   = 2'd0;
            end else if (w_bcd[23:20] != 4'd0) begin
               w_res_digits_nxt = w_bcd[23:8];
               w_res_frac_nxt   = 2'd1;
            end else if (w_bcd[19:16] != 4'd0) begin
               w_res_digits_nxt = w_bcd[19:4];
               w_res_frac_nxt   = 2'd2;
            end else begin
               w_res_digits_nxt = w_bcd[15:0];
               w_res_frac_nxt   = 2'd3;
            end
            w_res_neg_nxt = w_sign && (w_bcd != 32'd0);
            w_res_nan_nxt = 1'b0;
            w_res_ovf_nxt = 1'b0;
            w_state_nxt   = S_FINISH;
         end
         S_FINISH: begin
            w_digits_nxt = r_res_digits;
            w_frac_nxt   = r_res_frac;
            w_neg_nxt    = r_res_neg;
            w_nan_nxt    = r_res_nan;
            w_ovf_nxt    = r_res_ovf;
            w_done_nxt   = 1'b1;
            w_busy_nxt   = 1'b0;
            w_state_nxt  = S_IDLE;
         end
         default: begin
            w_busy_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Datapath, staging and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bf16       <= 16'd0;
         r_err        <= 1'b0;
         r_n          <= '0;
         r_res_digits <= 16'd0;
         r_res_frac   <= 2'd0;
         r_res_neg    <= 1'b0;
         r_res_nan    <= 1'b0;
         r_res_ovf    <= 1'b0;
         r_digits     <= 16'd0;
         r_frac       <= 2'd0;
         r_neg        <= 1'b0;
         r_nan        <= 1'b0;
         r_ovf        <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_bf16       <= w_bf16_nxt;
         r_err        <= w_err_nxt;
         r_n          <= w_n_nxt;
         r_res_digits <= w_res_digits_nxt;
         r_res_frac   <= w_res_frac_nxt;
         r_res_neg    <= w_res_neg_nxt;
         r_res_nan    <= w_res_nan_nxt;
         r_res_ovf    <= w_res_ovf_nxt;
         r_digits     <= w_digits_nxt;
         r_frac       <= w_frac_nxt;
         r_neg        <= w_neg_nxt;
         r_nan        <= w_nan_nxt;
         r_ovf        <= w_ovf_nxt;
         r_busy       <= w_busy_nxt;
         r_done       <= w_done_nxt;
      end
   end

   assign o_digits      = r_digits;
   assign o_frac_digits = r_frac;
   assign o_neg         = r_neg;
   assign o_nan         = r_nan;
   assign o_ovf         = r_ovf;
   assign o_busy        = r_busy;
   assign o_done        = r_done;

endmodule

// File: tb/tb_bf16_to_bcd_disp.sv
// Directed self-checking bench for bf16_to_bcd_disp with hand-computed vectors.
module tb_bf16_to_bcd_disp;

   logic        clk;
   logic        rst_n;
   logic        i_start;
   logic [15:0] i_bf16_in;
   logic        i_err_in;
   logic [15:0] o_digits;
   logic [1:0]  o_frac_digits;
   logic        o_neg;
   logic        o_nan;
   logic        o_ovf;
   logic        o_busy;
   logic        o_done;

   int n_tests = 0;
   int n_fail  = 0;

   bf16_to_bcd_disp dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_start       (i_start),
      .i_bf16_in     (i_bf16_in),
      .i_err_in      (i_err_in),
      .o_digits      (o_digits),
      .o_frac_digits (o_frac_digits),
      .o_neg         (o_neg),
      .o_nan         (o_nan),
      .o_ovf         (o_ovf),
      .o_busy        (o_busy),
      .o_done        (o_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   // Start one conversion; lat = clock edges from the sampling edge (1) to done seen.
   task automatic run_conv(input logic [15:0] v, input logic err, output int lat, output logic busy1);
      @(negedge clk);
      i_bf16_in = v;
      i_err_in  = err;
      i_start   = 1'b1;
      lat       = 0;
      busy1     = 1'b0;
      do begin
         @(posedge clk);
         #1;
         lat++;
         if (lat == 1) begin
            i_start = 1'b0;
            busy1   = o_busy;
         end
      end while (!o_done && lat < 60);
   endtask

   task automatic conv_check(input string tag, input logic [15:0] v, input logic err,
                             input int exp_lat, input logic [15:0] exp_dig, input logic [1:0] exp_frac,
                             input logic exp_neg, input logic exp_nan, input logic exp_ovf);
      int   lat;
      logic busy1;
      run_conv(v, err, lat, busy1);
      check({tag, ".latency"}, lat, exp_lat);
      check({tag, ".busy"}, {31'd0, busy1}, 32'd1);
      check({tag, ".digits"}, {16'd0, o_digits}, {16'd0, exp_dig});
      check({tag, ".nan"}, {31'd0, o_nan}, {31'd0, exp_nan});
      check({tag, ".ovf"}, {31'd0, o_ovf}, {31'd0, exp_ovf});
      if (!exp_nan && !exp_ovf) begin
         check({tag, ".frac"}, {30'd0, o_frac_digits}, {30'd0, exp_frac});
      end
      if (!exp_ovf) begin
         check({tag, ".neg"}, {31'd0, o_neg}, {31'd0, exp_neg});
      end
      @(posedge clk);
      #1;
      check({tag, ".done_pulse"}, {31'd0, o_done}, 32'd0);
      check({tag, ".busy_after"}, {31'd0, o_busy}, 32'd0);
      check({tag, ".hold"}, {16'd0, o_digits}, {16'd0, exp_dig});
   endtask

   initial begin
      int   cyc;
      int   done_cnt;
      int   done_cyc;
      int   busy_gap;
      rst_n     = 1'b0;
      i_start   = 1'b0;
      i_bf16_in = 16'd0;
      i_err_in  = 1'b0;
      #12;
      check("reset.digits", {16'd0, o_digits}, 32'd0);
      check("reset.flags", {26'd0, o_frac_digits, o_neg, o_nan, o_ovf, o_busy},  32'd0);
      check("reset.done", {31'd0, o_done}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      //          tag       value     err   lat  digits    frac neg nan ovf
      conv_check("half",    16'h3F00, 1'b0, 28, 16'h0500, 2'd3, 1'b0, 1'b0, 1'b0);
      conv_check("neg_one", 16'hBF80, 1'b0, 28, 16'h1000, 2'd3, 1'b1, 1'b0, 1'b0);
      conv_check("neg_zero",16'h8000, 1'b0, 28, 16'h0000, 2'd3, 1'b0, 1'b0, 1'b0);
      conv_check("hundred", 16'h42C8, 1'b0, 28, 16'h1000, 2'd1, 1'b0, 1'b0, 1'b0);
      conv_check("ten",     16'h4120, 1'b0, 28, 16'h1000, 2'd2, 1'b0, 1'b0, 1'b0);
      conv_check("n9984",   16'h461C, 1'b0, 28, 16'h9984, 2'd0, 1'b0, 1'b0, 1'b0);
      conv_check("round",   16'h3A83, 1'b0, 28, 16'h0001, 2'd3, 1'b0, 1'b0, 1'b0);
      conv_check("nan",     16'hFFC0, 1'b0,  3, 16'h0000, 2'd0, 1'b0, 1'b1, 1'b0);
      conv_check("err",     16'h3F00, 1'b1,  3, 16'h0000, 2'd0, 1'b0, 1'b1, 1'b0);
      conv_check("inf",     16'h7F80, 1'b0,  3, 16'h0000, 2'd0, 1'b0, 1'b0, 1'b1);
      conv_check("e141",    16'h469C, 1'b0,  3, 16'h0000, 2'd0, 1'b0, 1'b0, 1'b1);
      conv_check("n_ovf",   16'h461D, 1'b0, 27, 16'h0000, 2'd0, 1'b0, 1'b0, 1'b1);

      // start held 5 cycles plus a stray pulse mid-conversion: one conversion only
      @(negedge clk);
      i_bf16_in = 16'h3F00;
      i_err_in  = 1'b0;
      i_start   = 1'b1;
      done_cnt  = 0;
      done_cyc  = 0;
      busy_gap  = 0;
      for (int c = 1; c <= 45; c++) begin
         @(posedge clk);
         #1;
         if (c == 5 || c == 11) i_start = 1'b0;
         if (c == 10) i_start = 1'b1;
         if (o_done) begin
            done_cnt++;
            if (done_cyc == 0) done_cyc = c;
         end
         if (done_cnt == 0 && !o_busy) busy_gap++;
      end
      check("hold.done_count", done_cnt, 1);
      check("hold.done_cycle", done_cyc, 28);
      check("hold.busy_gap", busy_gap, 0);
      check("hold.digits", {16'd0, o_digits}, 32'h0500);

      // reset during BCD cycle 12 aborts without done
      conv_check("pre_rst", 16'h461C, 1'b0, 28, 16'h9984, 2'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      i_bf16_in = 16'h3F00;
      i_start   = 1'b1;
      cyc       = 0;
      while (cyc < 13) begin
         @(posedge clk);
         #1;
         cyc++;
         if (cyc == 1) i_start = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      check("abort.digits", {16'd0, o_digits}, 32'd0);
      check("abort.busy", {31'd0, o_busy}, 32'd0);
      check("abort.done", {31'd0, o_done}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n    = 1'b1;
      done_cnt = 0;
      for (int c = 0; c < 35; c++) begin
         @(posedge clk);
         #1;
         if (o_done) done_cnt++;
      end
      check("abort.no_done", done_cnt, 0);
      conv_check("post_rst", 16'h3F00, 1'b0, 28, 16'h0500, 2'd3, 1'b0, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/bf16_to_bcd_disp.md
Name: bf16_to_bcd_disp

Overview:
- Downstream stage of the trig/ALU result path: consumes the 16-bit BF16 `result` and `error` that the cos/sin unit produces on its `done` pulse.
- Converts the magnitude to a 4-digit decimal display word with decimal-point position, sign, NaN and overflow flags.
- Feeds the seven-segment driver.
- Sequential: decode/scale, 24-cycle double-dabble, then a digit-window select.

Parameters:
- SCALE, 1000: fixed-point decimal scale; 3 fractional digits max.
- NBITS, 24: width of the scaled integer N and of the double-dabble.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; samples bf16_in and err_in
- bf16_in  in  `INPUTOUTBIT (16)  BF16 value
- err_in  in  1  upstream error flag
- digits  out  16  packed BCD; [15:12] is the leftmost digit
- frac_digits  out  2  digits right of the decimal point (0..3)
- neg  out  1  value negative and nonzero
- nan  out  1  NaN input or err_in
- ovf  out  1  |x| not representable (Inf, or N >= 10_000_000)
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse; outputs valid from this cycle until the next accepted start

Behaviour:
- Reset (async, rst_n=0): digits=0, frac_digits=0, neg=0, nan=0, ovf=0, busy=0, done=0, state=IDLE. Reset mid-conversion aborts with no done pulse.
- States: IDLE, DECODE, BCD, SELECT, FINISH.
- IDLE:
  - start=1 latches the inputs and moves to DECODE.
  - start while busy is ignored.
  - done is cleared in every cycle it is not being pulsed.
- DECODE (1 cycle): s = bf16[15], e = bf16[14:7], m = {1, bf16[6:0]}.
  - err_in=1, or (e=255 and mantissa≠0): nan=1, digits=0, neg=0, ovf=0 -> FINISH.
  - e=255 with mantissa=0 (Inf), or e>=141: ovf=1, nan=0, digits=0 -> FINISH.
  - e=0 (zero/subnormal): N=0.
  - Otherwise: P = m*1000 (18 bits), sh = e-134.
    - sh>=0: N = P<<sh.
    - -18<=sh<0: N = (P + 2^(-sh-1)) >> -sh (round half up).
    - sh<-18: N=0.
  - Then go to BCD.
- BCD (exactly 24 cycles): shift-add-3 double-dabble of N into BCD digits D7..D0. Afterwards, if N>=10_000_000, set ovf=1 and go to FINISH; else go to SELECT.
- SELECT (1 cycle):
  - L = index of the highest nonzero digit among D6..D4; L=3 if D6..D4 are all zero.
  - digits = {D_L, D_L-1, D_L-2, D_L-3}; frac_digits = 6-L. Lower digits are truncated.
  - neg = s and (N≠0); nan=0, ovf=0.
- FINISH (1 cycle): done=1, busy=0, return to IDLE.
- Latency, counted from the start-sampling edge to the done-high cycle:
  - normal path: 28 cycles (DECODE 1, BCD 24, SELECT 1, FINISH 1, +1 for the output register);
  - NaN/Inf/e>=141 path: 3 cycles.
- A start pulse on the same edge as done/FINISH is accepted only once IDLE is reached; upstream issues at most one start per upstream done.
- Outputs hold their values between conversions.

Decomposition:
- define.vh additions:
  - BF16 field widths (sign 1, exp 8, frac 7);
  - BF16_NAN 16'hFFC0;
  - BF16_EXP_BIAS 127;
  - DISP_DIGITS 4;
  - DISP_SCALE 1000;
  - OVF exponent threshold 141;
  - state encodings.
- Sub-module: bin_to_bcd, a sequential 24-bit double-dabble with start/done and 8 BCD digits out. The FSM here owns decode, scaling and window select.

Test Plan:
- bf16_in=16'h3F00 (0.5) -> N=500; digits=16'h0500, frac_digits=3, neg=0, done 28 cycles after start.
- bf16_in=16'hBF80 (-1.0, cos 180°) -> digits=16'h1000, frac_digits=3, neg=1; 16'h8000 (-0) -> digits=0, neg=0.
- bf16_in=16'h42C8 (100.0) -> digits=16'h1000, frac_digits=1; 16'h461C (9984) -> digits=16'h9984, frac_digits=0; 16'h3A83 (~0.0009995) -> digits=16'h0001, frac_digits=3 (round half up).
- bf16_in=16'hFFC0, or err_in=1 with any value -> nan=1, digits=0, done 3 cycles after start; 16'h7F80 or 16'h469C (20000) -> ovf=1, nan=0.
- Hold start high for 5 cycles, and pulse start at cycle 10 of a conversion -> exactly one conversion, busy continuous, one done pulse.
- Assert rst_n=0 in BCD cycle 12 -> all outputs 0 immediately, no done; a fresh 16'h3F00 after release converts correctly.
